// File: rtl/float_div_pkg.sv
// rtl/float_div_pkg.sv - shared bfloat16 divider constants and state type
package float_div_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 7;
  localparam int BIAS  = 127;

  localparam logic [15:0]      QNAN    = 16'h7FC0;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_e;

endpackage

// File: rtl/mant_div.sv
// rtl/mant_div.sv - 9-step restoring mantissa divider, one quotient bit per cycle
module mant_div
  import float_div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [MAN_W:0]   m1_i,
  input  logic [MAN_W:0]   m2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [8:0]       q_o
);

  logic [8:0]     r_q;
  logic [7:0]     q_q;
  logic [MAN_W:0] m2_q;
  logic [3:0]     cnt_q;
  logic           busy_q;

  logic           ge;
  logic [7:0]     rem;
  logic [8:0]     r_d;
  logic [7:0]     q_d;

  // One restoring step; after a subtract the remainder is below M2 so 8 bits hold it.
  always_comb begin
    ge  = (r_q >= {1'b0, m2_q});
    rem = ge ? 8'(r_q - {1'b0, m2_q}) : r_q[7:0];
    r_d = {rem, 1'b0};
    q_d = {q_q[6:0], ge};
  end

  // Load operands on start, then iterate nine times; counter wraps to 0 when finished.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= 4'd0;
      r_q    <= '0;
      q_q    <= '0;
      m2_q   <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= 4'd0;
      r_q    <= {1'b0, m1_i};
      q_q    <= '0;
      m2_q   <= m2_i;
    end else if (busy_q) begin
      r_q <= r_d;
      q_q <= q_d;
      if (cnt_q == 4'd8) begin
        busy_q <= 1'b0;
        cnt_q  <= 4'd0;
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  // done marks the cycle whose edge performs the last step; q_o already includes that bit.
  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == 4'd8);
  assign q_o    = {q_q, ge};

endmodule

// File: rtl/float_div_seq.sv
// rtl/float_div_seq.sv - iterative bfloat16 divider with valid/ready handshakes
module float_div_seq
  import float_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:15] num1,
  input  logic [0:15] num2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:15] out
);

  state_e state_q, state_d;
  logic [0:15] out_q, out_d;

  logic             spec_q;
  logic [0:15]      spec_val_q;
  logic             sign_q;
  logic [EXP_W-1:0] ex1_q, ex2_q;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic             s_in;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic             spec_hit;
  logic [0:15]      spec_val;
  logic             accept;

  logic             div_busy, div_done;
  logic [8:0]       div_q;
  logic             adj;
  logic [MAN_W-1:0] man;
  logic [9:0]       e_u;
  logic signed [9:0] e_s;
  logic [0:15]      pack_val;

  assign ea   = num1[1:8];
  assign eb   = num2[1:8];
  assign ma   = num1[9:15];
  assign mb   = num2[9:15];
  assign s_in = num1[0] ^ num2[0];

  assign in_ready  = (state_q == IDLE) && !div_busy;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign out       = out_q;

  // Classify the incoming operands; exponent 0 counts as zero, so denormals flush.
  always_comb begin
    a_zero   = (ea == '0);
    b_zero   = (eb == '0);
    a_inf    = (ea == EXP_MAX) && (ma == '0);
    b_inf    = (eb == EXP_MAX) && (mb == '0);
    a_nan    = (ea == EXP_MAX) && (ma != '0);
    b_nan    = (eb == EXP_MAX) && (mb != '0);
    spec_hit = 1'b1;
    spec_val = QNAN;
    if (a_nan || b_nan) begin
      spec_val = QNAN;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_val = QNAN;
    end else if (b_zero || a_inf) begin
      spec_val = {s_in, EXP_MAX, {MAN_W{1'b0}}};
    end else if (a_zero || b_inf) begin
      spec_val = {s_in, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  mant_div u_mant_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (accept && !spec_hit),
    .m1_i    ({1'b1, ma}),
    .m2_i    ({1'b1, mb}),
    .busy_o  (div_busy),
    .done_o  (div_done),
    .q_o     (div_q)
  );

  // Normalize the final quotient (truncating) and clamp the exponent into inf or zero.
  always_comb begin
    adj = ~div_q[8];
    man = div_q[8] ? div_q[7:1] : div_q[6:0];
    e_u = {2'b00, ex1_q} - {2'b00, ex2_q} + 10'(BIAS) - {9'd0, adj};
    e_s = $signed(e_u);
    if (e_s >= 10'sd255) begin
      pack_val = {sign_q, EXP_MAX, {MAN_W{1'b0}}};
    end else if (e_s <= 10'sd0) begin
      pack_val = {sign_q, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
    end else begin
      pack_val = {sign_q, e_u[7:0], man};
    end
  end

  // Next-state and output-register logic; special results spend one cycle in DIV
  // so they present out_valid one edge after acceptance.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = DIV;
        end
      end
      DIV: begin
        if (spec_q) begin
          state_d = DONE;
          out_d   = spec_val_q;
        end else if (div_done) begin
          state_d = DONE;
          out_d   = pack_val;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, result and captured-operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      out_q      <= '0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      sign_q     <= 1'b0;
      ex1_q      <= '0;
      ex2_q      <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      if (accept) begin
        spec_q     <= spec_hit;
        spec_val_q <= spec_val;
        sign_q     <= s_in;
        ex1_q      <= ea;
        ex2_q      <= eb;
      end
    end
  end

endmodule

// File: tb/tb_float_div_seq.sv
// tb/tb_float_div_seq.sv - directed table-driven bench for float_div_seq
module tb_float_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [0:15] num1 = 16'h0000;
  logic [0:15] num2 = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [0:15] out;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] n1;
    logic [15:0] n2;
    logic [15:0] exp_out;
    int          exp_lat;
    string       name;
  } vec_t;

  vec_t vecs[13];

  float_div_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num1      (num1),
    .num2      (num2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_in_ready(input string name);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " in_ready"}, 32'(in_ready), 32'd1);
  endtask

  // Returns number of edges after the accept edge until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic accept_pair(input logic [15:0] n1, input logic [15:0] n2);
    num1 = n1;
    num2 = n2;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    num1 = 16'hFFFF;
    num2 = 16'h1234;
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, " out_valid drop"}, 32'(out_valid), 32'd0);
    check({name, " in_ready rise"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input vec_t v);
    int lat;
    wait_in_ready(v.name);
    accept_pair(v.n1, v.n2);
    wait_result(lat);
    check({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
    check({v.name, " out"}, {16'h0, out}, {16'h0, v.exp_out});
    handshake(v.name);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{16'h4040, 16'h4000, 16'h3FC0, 9, "3/2"};
    vecs[1]  = '{16'h3F80, 16'h4040, 16'h3EAA, 9, "1/3"};
    vecs[2]  = '{16'hC000, 16'h3F80, 16'hC000, 9, "-2/1"};
    vecs[3]  = '{16'h3F80, 16'hBF80, 16'hBF80, 9, "1/-1"};
    vecs[4]  = '{16'h3F80, 16'h0000, 16'h7F80, 1, "1/0"};
    vecs[5]  = '{16'h0000, 16'h0000, 16'h7FC0, 1, "0/0"};
    vecs[6]  = '{16'h0000, 16'h4000, 16'h0000, 1, "0/2"};
    vecs[7]  = '{16'h7FC1, 16'h3F80, 16'h7FC0, 1, "nan/1"};
    vecs[8]  = '{16'h7F80, 16'h7F80, 16'h7FC0, 1, "inf/inf"};
    vecs[9]  = '{16'h4000, 16'h7F80, 16'h0000, 1, "2/inf"};
    vecs[10] = '{16'hFF80, 16'h4000, 16'hFF80, 1, "-inf/2"};
    vecs[11] = '{16'h7F00, 16'h0080, 16'h7F80, 9, "overflow"};
    vecs[12] = '{16'h0080, 16'h7F00, 16'h0000, 9, "underflow"};

    #12;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out", {16'h0, out}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // out_ready while idle must be ignored
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle out_ready ignored", 32'(out_valid), 32'd0);

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i]);
    end

    // Backpressure: result held while out_ready is low, extra operands ignored
    wait_in_ready("bp");
    accept_pair(16'h4040, 16'h4000);
    wait_result(lat);
    check("bp latency", 32'(lat), 32'd9);
    num1 = 16'h3F80;
    num2 = 16'h0000;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp out_valid held", 32'(out_valid), 32'd1);
      check("bp out stable", {16'h0, out}, 32'h3FC0);
      check("bp in_ready low", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    handshake("bp");
    accept_pair(16'hC000, 16'h3F80);
    check("bp next accepted", 32'(in_ready), 32'd0);
    wait_result(lat);
    check("bp next latency", 32'(lat), 32'd9);
    check("bp next out", {16'h0, out}, 32'hC000);
    handshake("bp next");

    // Reset in the middle of an iteration
    wait_in_ready("rst");
    accept_pair(16'h3F80, 16'h4040);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("rst busy in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out", {16'h0, out}, 32'h0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    #2;
    rst_n = 1'b1;
    run_op(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
